// File: rtl/fm_pkg.sv
// rtl/fm_pkg.sv - shared mode/interpolator encodings and midscale helper for the FM modulator
package fm_pkg;

    typedef enum logic [1:0] {
        MODE_OFF  = 2'd0,
        MODE_CW   = 2'd1,
        MODE_FM   = 2'd2,
        MODE_RSVD = 2'd3
    } fm_mode_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RAMP = 2'd1,
        ST_HOLD = 2'd2
    } interp_state_t;

    function automatic int unsigned midscale(input int unsigned d);
        return 32'd1 << (d - 1);
    endfunction

endpackage

// File: rtl/fm_sine_approx.sv
// rtl/fm_sine_approx.sv - piecewise-linear sine from phase, two-stage registered, offset-binary out
module fm_sine_approx
    import fm_pkg::*;
#(
    parameter int N = 18,
    parameter int D = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] acc,
    input  logic         en,
    output logic [D-1:0] rf
);

    localparam int unsigned H_I   = midscale(D);
    localparam int unsigned QH_I  = H_I / 4;
    localparam logic [D-1:0] H_D  = H_I[D-1:0];
    localparam logic [D-2:0] QH   = QH_I[D-2:0];
    localparam logic [D-2:0] MAG_MAX = {(D-1){1'b1}};

    logic [1:0]   quad;
    logic [D-2:0] p;
    logic [D-1:0] p2;
    logic [D-2:0] mag_c;
    logic [D-2:0] mag_q;
    logic         neg_q;
    logic         unused_low;

    assign quad       = acc[N-1:N-2];
    // Folding only the bits that feed the magnitude is equivalent to folding the whole phase.
    assign p          = quad[0] ? ~acc[N-3 -: D-1] : acc[N-3 -: D-1];
    assign p2         = {p, 1'b0};
    assign unused_low = ^acc[N-D-2:0];

    always_comb begin
        mag_c = MAG_MAX;
        case (p[D-2 -: 2])
            2'b00:        mag_c = (p2 > {1'b0, MAG_MAX}) ? MAG_MAX : p2[D-2:0];
            2'b01, 2'b10: mag_c = QH + p;
            default:      mag_c = MAG_MAX;
        endcase
    end

    // A zero magnitude is the midscale point, so disabling simply forces it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mag_q <= '0;
            neg_q <= 1'b0;
            rf    <= H_D;
        end else begin
            mag_q <= en ? mag_c : '0;
            neg_q <= en & quad[1];
            rf    <= neg_q ? (H_D - {1'b0, mag_q}) : (H_D + {1'b0, mag_q});
        end
    end

endmodule

// File: rtl/fm_mod_interp.sv
// rtl/fm_mod_interp.sv - FM modulator with linear audio interpolation and phase accumulator
module fm_mod_interp
    import fm_pkg::*;
#(
    parameter int A  = 8,
    parameter int N  = 18,
    parameter int D  = 5,
    parameter int IW = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic signed [A-1:0] audio,
    input  logic                audio_valid,
    output logic                audio_ready,
    input  logic [N-1:0]        acc_inc,
    input  logic [2:0]          dev_shift,
    input  logic [1:0]          mode,
    output logic [D-1:0]        rf
);

    localparam int FW = A + 1 + IW;

    interp_state_t      state;
    logic signed [A:0]  step;
    logic signed [A:0]  interp;
    logic [FW-1:0]      frac;
    logic [IW-1:0]      cnt;
    logic [N-1:0]       acc;
    logic [N-1:0]       interp_n;
    logic [N-1:0]       mod_inc;
    logic [N-1:0]       fm_term;
    logic               mode_on;
    logic               on_q;
    logic               take;

    assign take     = audio_valid & audio_ready;
    // Taking the upper bits is the arithmetic right shift by IW.
    assign interp   = frac[FW-1:IW];
    assign interp_n = {{(N-A-1){interp[A]}}, interp};
    assign mod_inc  = interp_n << dev_shift;
    assign mode_on  = (mode == MODE_CW) || (mode == MODE_FM);
    assign fm_term  = (mode == MODE_FM) ? mod_inc : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            audio_ready <= 1'b1;
            step        <= '0;
            frac        <= '0;
            cnt         <= '0;
        end else begin
            case (state)
                ST_RAMP: begin
                    frac <= frac + {{IW{step[A]}}, step};
                    cnt  <= cnt + IW'(1);
                    if (cnt == '1) begin
                        state       <= ST_HOLD;
                        audio_ready <= 1'b1;
                    end
                end
                default: begin
                    if (take) begin
                        step        <= {audio[A-1], audio} - interp;
                        cnt         <= '0;
                        state       <= ST_RAMP;
                        audio_ready <= 1'b0;
                    end
                end
            endcase
        end
    end

    // on_q travels with acc so the sine pipeline blanks exactly when acc freezes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc  <= '0;
            on_q <= 1'b0;
        end else begin
            on_q <= mode_on;
            if (mode_on) begin
                acc <= acc + acc_inc + fm_term;
            end
        end
    end

    fm_sine_approx #(
        .N (N),
        .D (D)
    ) u_sine (
        .clk (clk),
        .rst (rst),
        .acc (acc),
        .en  (on_q),
        .rf  (rf)
    );

endmodule
